lcd_bus_arbiter: RTL and testbench

- Shares the 8080-style parallel LCD write bus (cs_n, d_c_n, wr_n, 16-bit data) between two requesters: a CPU command/register path and the pixel DMA stream.
- Sequences write strobes with programmable low/high phase widths.
- Grants DMA in bounded bursts and round-robins on ties.
- Sits between the Avalon-side CPU command register and the DMA controller on one side, and the LCD conduit pins on the other.

---
 rtl/lcd_arb_pkg.sv | 23 ++
 rtl/lcd_arb_wr_phase_timer.sv | 28 ++
 rtl/lcd_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared types and sizing helpers for the LCD bus arbiter.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CMD = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // The phase timer only ever holds (cycles - 1), so the larger phase sets the width.
  function automatic int phase_cnt_w(input int lo, input int hi);
    int m;
    m = (lo > hi) ? lo : hi;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lcd_arb_wr_phase_timer.sv
// Loadable down-counter timing the wr_n low/high phases; done at terminal count.
module lcd_wr_phase_timer
  import lcd_arb_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates the 8080 LCD write bus between CPU commands and pixel DMA bursts.
// Build option LCD_ARB_STATS_EN adds accepted-word counters with a synchronous clear.
//
// state | meaning
// IDLE  | bus released (cs_n high), arbitrating between CMD and DMA
// SETUP | cs_n low, word and d_c_n presented, wr_n still high
// WR_LO | wr_n low for WR_LOW_CYC cycles
// WR_HI | wr_n high for WR_HIGH_CYC cycles; last cycle may chain the next DMA word
module lcd_bus_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int DMA_BURST   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dc,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              dma_last,
  output logic              busy,
  output logic              lcd_cs_n,
  output logic              lcd_d_c_n,
  output logic              lcd_wr_n,
  output logic [DATA_W-1:0] lcd_data
`ifdef LCD_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_cmd_cnt,
  output logic [31:0]       stat_pix_cnt
`endif
);

  localparam int PW = phase_cnt_w(WR_LOW_CYC, WR_HIGH_CYC);
  localparam int BW = $clog2(DMA_BURST + 1);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt, last_owner, last_owner_nxt;
  logic [BW-1:0]     burst_cnt, burst_nxt;
  logic              cur_last, cur_last_nxt;
  logic              cs_n_nxt, wr_n_nxt, dc_n_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              ph_load, ph_done;
  logic [PW-1:0]     ph_val;
  logic              grant_cmd, grant_dma, chain;

  lcd_wr_phase_timer #(.W(PW)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .done     (ph_done)
  );

  // Ties go to whoever did not own the bus last.
  assign grant_cmd = (state == IDLE) && cmd_valid && (!dma_valid || last_owner == OWN_DMA);
  assign grant_dma = (state == IDLE) && dma_valid && !grant_cmd;
  assign chain     = (state == WR_HI) && ph_done && (owner == OWN_DMA) && dma_valid &&
                     !cur_last && ((int'(burst_cnt) + 1) < DMA_BURST);

  // Gated so that ready reads 0 for the whole time reset is asserted.
  assign cmd_ready = grant_cmd && !reset;
  assign dma_ready = (grant_dma || chain) && !reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_DMA;
      last_owner <= OWN_DMA;
      burst_cnt  <= '0;
      cur_last   <= 1'b0;
      lcd_cs_n   <= 1'b1;
      lcd_wr_n   <= 1'b1;
      lcd_d_c_n  <= 1'b1;
      lcd_data   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_nxt;
      cur_last   <= cur_last_nxt;
      lcd_cs_n   <= cs_n_nxt;
      lcd_wr_n   <= wr_n_nxt;
      lcd_d_c_n  <= dc_n_nxt;
      lcd_data   <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_cmd || grant_dma) state_nxt = SETUP;
      SETUP:   state_nxt = WR_LO;
      WR_LO:   if (ph_done) state_nxt = WR_HI;
      WR_HI:   if (ph_done) state_nxt = chain ? WR_LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_n_nxt       = lcd_cs_n;
    wr_n_nxt       = lcd_wr_n;
    dc_n_nxt       = lcd_d_c_n;
    data_nxt       = lcd_data;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_nxt      = burst_cnt;
    cur_last_nxt   = cur_last;
    ph_load        = 1'b0;
    ph_val         = PW'(WR_LOW_CYC - 1);
    case (state)
      IDLE: begin
        if (grant_cmd) begin
          cs_n_nxt     = 1'b0;
          dc_n_nxt     = cmd_dc;
          data_nxt     = cmd_data;
          owner_nxt    = OWN_CMD;
          burst_nxt    = '0;
          cur_last_nxt = 1'b0;
        end else if (grant_dma) begin
          cs_n_nxt     = 1'b0;
          dc_n_nxt     = 1'b1;
          data_nxt     = dma_data;
          owner_nxt    = OWN_DMA;
          burst_nxt    = '0;
          cur_last_nxt = dma_last;
        end
      end
      SETUP: begin
        wr_n_nxt = 1'b0;
        ph_load  = 1'b1;
      end
      WR_LO: begin
        if (ph_done) begin
          wr_n_nxt = 1'b1;
          ph_load  = 1'b1;
          ph_val   = PW'(WR_HIGH_CYC - 1);
        end
      end
      WR_HI: begin
        if (ph_done) begin
          if (chain) begin
            wr_n_nxt     = 1'b0;
            data_nxt     = dma_data;
            burst_nxt    = burst_cnt + BW'(1);
            cur_last_nxt = dma_last;
            ph_load      = 1'b1;
          end else begin
            cs_n_nxt       = 1'b1;
            last_owner_nxt = owner;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef LCD_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cmd_cnt <= '0;
      stat_pix_cnt <= '0;
    end else if (stat_clr) begin
      stat_cmd_cnt <= '0;
      stat_pix_cnt <= '0;
    end else begin
      if (grant_cmd) stat_cmd_cnt <= stat_cmd_cnt + 32'd1;
      if (grant_dma || chain) stat_pix_cnt <= stat_pix_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed scenarios plus random traffic against a cycle-offset model.
// Stats ports are exercised when LCD_ARB_STATS_EN is defined.
module tb_lcd_bus_arbiter;

  localparam int DW = 16;
  localparam int L  = 2;
  localparam int H  = 2;
  localparam int B  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_dc;
  logic [DW-1:0] cmd_data;
  logic          dma_valid, dma_ready, dma_last;
  logic [DW-1:0] dma_data;
  logic          busy, lcd_cs_n, lcd_d_c_n, lcd_wr_n;
  logic [DW-1:0] lcd_data;
`ifdef LCD_ARB_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_cmd_cnt, stat_pix_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .DATA_W(DW), .WR_LOW_CYC(L), .WR_HIGH_CYC(H), .DMA_BURST(B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dc    (cmd_dc),
    .cmd_data  (cmd_data),
    .dma_valid (dma_valid),
    .dma_ready (dma_ready),
    .dma_data  (dma_data),
    .dma_last  (dma_last),
    .busy      (busy),
    .lcd_cs_n  (lcd_cs_n),
    .lcd_d_c_n (lcd_d_c_n),
    .lcd_wr_n  (lcd_wr_n),
    .lcd_data  (lcd_data)
`ifdef LCD_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_cmd_cnt (stat_cmd_cnt),
    .stat_pix_cnt (stat_pix_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a grant is a sequence of word slots; each slot is measured by its cycle offset
  // from the wr_n falling edge (the first slot of a grant has one extra setup cycle).
  bit            m_active, m_first, m_own_dma, m_cur_last, m_dc;
  bit            m_last_own_dma = 1'b1;
  logic [DW-1:0] m_data;
  int            m_k, m_words;
  int            n_cmd_acc = 0, n_dma_acc = 0, n_strobe = 0, n_cs_low = 0, n_wr_low = 0;
  bit            prev_wr = 1'b1, prev_cs = 1'b1;
  logic [DW:0]   strobe_log[$];
  int            rise_log[$];

  always @(negedge clk) begin
    int o;
    bit e_cs, e_wr, e_cr, e_dr;
    if (reset) begin
      m_active       = 1'b0;
      m_last_own_dma = 1'b1;
      m_data         = '0;
      m_dc           = 1'b1;
      prev_wr        = 1'b1;
      prev_cs        = 1'b1;
    end else begin
      o    = m_first ? m_k - 1 : m_k;
      e_cs = !m_active;
      e_wr = !(m_active && o >= 0 && o < L);
      e_cr = 1'b0;
      e_dr = 1'b0;
      if (!m_active) begin
        if (cmd_valid && (!dma_valid || m_last_own_dma)) e_cr = 1'b1;
        else if (dma_valid) e_dr = 1'b1;
      end else if (o == L + H - 1) begin
        e_dr = m_own_dma && dma_valid && (m_words < B) && !m_cur_last;
      end
      check_val("cs_n", lcd_cs_n, e_cs);
      check_val("wr_n", lcd_wr_n, e_wr);
      check_val("d_c_n", lcd_d_c_n, m_dc);
      check_val("data", lcd_data, m_data);
      check_val("busy", busy, m_active);
      check_val("cmd_ready", cmd_ready, e_cr);
      check_val("dma_ready", dma_ready, e_dr);

      if (!lcd_cs_n) n_cs_low++;
      if (!lcd_wr_n) n_wr_low++;
      if (lcd_wr_n && !prev_wr) begin
        n_strobe++;
        strobe_log.push_back({lcd_d_c_n, lcd_data});
      end
      if (lcd_cs_n && !prev_cs) rise_log.push_back(n_strobe);
      prev_wr = lcd_wr_n;
      prev_cs = lcd_cs_n;

      if (!m_active) begin
        if (e_cr || e_dr) begin
          m_active   = 1'b1;
          m_first    = 1'b1;
          m_k        = 0;
          m_words    = 1;
          m_own_dma  = e_dr;
          m_data     = e_cr ? cmd_data : dma_data;
          m_dc       = e_cr ? cmd_dc : 1'b1;
          m_cur_last = e_dr && dma_last;
          if (e_cr) n_cmd_acc++;
          else n_dma_acc++;
        end
      end else if (o == L + H - 1) begin
        if (e_dr) begin
          m_first    = 1'b0;
          m_k        = 0;
          m_words++;
          m_data     = dma_data;
          m_cur_last = dma_last;
          n_dma_acc++;
        end else begin
          m_active       = 1'b0;
          m_last_own_dma = m_own_dma;
        end
      end else begin
        m_k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((m_active || cmd_valid || dma_valid) && c < 2000) begin
      tick();
      c++;
    end
    check_val("idle_timeout", c < 2000, 1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    dma_valid = 1'b0;
    dma_last  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_cmd(input bit dc, input logic [DW-1:0] d);
    int n0, c;
    n0 = n_cmd_acc;
    c  = 0;
    cmd_valid = 1'b1;
    cmd_dc    = dc;
    cmd_data  = d;
    while (n_cmd_acc == n0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    check_val("cmd_accept_timeout", n_cmd_acc != n0, 1);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic dma_stream(input int n, input int last_at, input logic [DW-1:0] base);
    int n0, c;
    dma_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      dma_data = base + DW'(i);
      dma_last = (i == last_at);
      n0 = n_dma_acc;
      c  = 0;
      while (n_dma_acc == n0 && c < 500) begin
        @(posedge clk);
        c++;
      end
      check_val("dma_accept_timeout", n_dma_acc != n0, 1);
      #1;
    end
    dma_valid = 1'b0;
    dma_last  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, cl0, wl0, q0, r0, c;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_dc = 1'b0; cmd_data = '0;
    dma_valid = 1'b0; dma_last = 1'b0; dma_data = '0;
`ifdef LCD_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) tick();
    check_val("rst_cs_n", lcd_cs_n, 1);
    check_val("rst_wr_n", lcd_wr_n, 1);
    check_val("rst_d_c_n", lcd_d_c_n, 1);
    check_val("rst_data", lcd_data, 0);
    check_val("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // single command word
    s0 = n_strobe; cl0 = n_cs_low; wl0 = n_wr_low;
    send_cmd(1'b0, 16'h002C);
    wait_idle();
    check_val("cmd_strobes", n_strobe - s0, 1);
    check_val("cmd_cs_low_cycles", n_cs_low - cl0, 5);
    check_val("cmd_wr_low_cycles", n_wr_low - wl0, 2);
    check_val("cmd_word_latched", strobe_log[strobe_log.size() - 1], {1'b0, 16'h002C});

    // 40-word stream splits into a capped burst of 32 and a burst of 8
    s0 = n_strobe; r0 = rise_log.size();
    dma_stream(40, -1, 16'h1000);
    wait_idle();
    check_val("dma40_strobes", n_strobe - s0, 40);
    check_val("dma40_cs_rises", rise_log.size() - r0, 2);
    check_val("dma40_first_burst", rise_log[r0] - s0, 32);

    // reset in the middle of a write-low phase
    dma_valid = 1'b1; dma_data = 16'hBEEF; dma_last = 1'b0;
    c = 0;
    while (lcd_wr_n && c < 50) begin tick(); c++; end
    check_val("wr_lo_reached", lcd_wr_n, 0);
    cmd_valid = 1'b1; cmd_dc = 1'b1; cmd_data = 16'h1234;
    #1 reset = 1'b1;
    #1;
    check_val("async_cs_n", lcd_cs_n, 1);
    check_val("async_wr_n", lcd_wr_n, 1);
    check_val("async_d_c_n", lcd_d_c_n, 1);
    check_val("async_data", lcd_data, 0);
    check_val("async_busy", busy, 0);
    check_val("async_cmd_ready", cmd_ready, 0);
    check_val("async_dma_ready", dma_ready, 0);
    cmd_valid = 1'b0; dma_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // both valid after reset: CMD, DMA, CMD
    q0 = strobe_log.size();
    cmd_valid = 1'b1; cmd_dc = 1'b0; cmd_data = 16'h00AA;
    dma_valid = 1'b1; dma_data = 16'h5555; dma_last = 1'b1;
    c = 0;
    while (strobe_log.size() < q0 + 3 && c < 200) begin tick(); c++; end
    cmd_valid = 1'b0; dma_valid = 1'b0; dma_last = 1'b0;
    check_val("tie_timeout", c < 200, 1);
    wait_idle();
    check_val("tie_first_cmd", strobe_log[q0], {1'b0, 16'h00AA});
    check_val("tie_then_dma", strobe_log[q0 + 1], {1'b1, 16'h5555});
    check_val("tie_cmd_again", strobe_log[q0 + 2], {1'b0, 16'h00AA});

    // dma_last on word 5 ends the burst while dma_valid stays high
    s0 = n_strobe; r0 = rise_log.size();
    dma_stream(6, 4, 16'h2000);
    wait_idle();
    check_val("last_burst_len", rise_log[r0] - s0, 5);
    check_val("last_total", n_strobe - s0, 6);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 4) == 0);
      cmd_dc    = 1'($urandom);
      cmd_data  = DW'($urandom);
      dma_valid = (i % 1000 < 500) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) != 0);
      dma_data  = DW'($urandom);
      dma_last  = ($urandom_range(0, 19) == 0);
      tick();
    end
    cmd_valid = 1'b0; dma_valid = 1'b0; dma_last = 1'b0;
    wait_idle();

`ifdef LCD_ARB_STATS_EN
    do_reset();
    check_val("stat_rst_cmd", stat_cmd_cnt, 0);
    for (int i = 0; i < 3; i++) send_cmd(1'b1, DW'(16'h0300 + i));
    dma_stream(10, -1, 16'h4000);
    wait_idle();
    check_val("stat_cmd_cnt", stat_cmd_cnt, 3);
    check_val("stat_pix_cnt", stat_pix_cnt, 10);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_val("stat_clr_cmd", stat_cmd_cnt, 0);
    check_val("stat_clr_pix", stat_pix_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
